// File: rtl/bn_pkg.sv
// rtl/bn_pkg.sv - shared state encoding and fixed-point scale for the BN sequencer
package bn_pkg;

  // Job sequencing states; one element walks RD -> ISSUE -> CAPT.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_ISSUE,
    S_CAPT,
    S_FIN
  } bn_state_t;

  // p and q are fixed-point values carrying this scale factor.
  localparam int BN_SCALE = 1000;

endpackage

// File: rtl/bn_param_table.sv
// rtl/bn_param_table.sv - per-channel {p, q} table, synchronous write, combinational read
module bn_param_table #(
  parameter int CH = 8,
  parameter int CW = $clog2(CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [CW-1:0] wr_ch,
  input  logic [15:0]   wr_p,
  input  logic [31:0]   wr_q,
  input  logic [CW-1:0] rd_ch,
  output logic [15:0]   rd_p,
  output logic [31:0]   rd_q
);

  logic [15:0] p_mem [CH];
  logic [31:0] q_mem [CH];

  // Reset clears every entry; writes to channels beyond CH are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        p_mem[i] <= '0;
        q_mem[i] <= '0;
      end
    end else if (we && (int'(wr_ch) < CH)) begin
      p_mem[wr_ch] <= wr_p;
      q_mem[wr_ch] <= wr_q;
    end
  end

  assign rd_p = p_mem[rd_ch];
  assign rd_q = q_mem[rd_ch];

endmodule

// File: rtl/bn_sequencer.sv
// rtl/bn_sequencer.sv - walks every sample through the external PE, channel-major
module bn_sequencer
  import bn_pkg::*;
#(
  parameter  int CH  = 8,
  parameter  int LEN = 16,
  localparam int CW  = $clog2(CH),
  localparam int AW  = $clog2(CH * LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          prm_we,
  input  logic [CW-1:0] prm_ch,
  input  logic [15:0]   prm_p,
  input  logic [31:0]   prm_q,
  output logic          in_rd,
  output logic [AW-1:0] in_addr,
  input  logic [15:0]   in_data,
  output logic          pe_clr,
  output logic          pe_start,
  output logic [15:0]   pe_x,
  output logic [15:0]   pe_p,
  output logic [31:0]   pe_q,
  input  logic [15:0]   pe_odata,
  input  logic          pe_done,
  output logic          out_we,
  output logic [AW-1:0] out_addr,
  output logic [15:0]   out_data
);

  localparam int            NW     = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [AW-1:0] K_LAST = AW'(CH * LEN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(LEN - 1);

  bn_state_t     state, state_nxt;
  logic [AW-1:0] k;
  logic [CW-1:0] ch_idx;
  logic [NW-1:0] n_idx;
  logic [15:0]   tbl_p;
  logic [31:0]   tbl_q;
  logic          k_last;

  assign k_last = (k == K_LAST);
  assign busy   = (state != S_IDLE);

  // Table is only writable between jobs so a running job sees stable parameters.
  bn_param_table #(.CH(CH), .CW(CW)) u_tbl (
    .clk   (clk),
    .rst   (rst),
    .we    (prm_we && (state == S_IDLE)),
    .wr_ch (prm_ch),
    .wr_p  (prm_p),
    .wr_q  (prm_q),
    .rd_ch (ch_idx),
    .rd_p  (tbl_p),
    .rd_q  (tbl_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Element index k with its channel/sample split, kept in step to avoid a divider.
  always_ff @(posedge clk) begin
    if (rst || state == S_CLR) begin
      k      <= '0;
      ch_idx <= '0;
      n_idx  <= '0;
    end else if (state == S_CAPT && !k_last) begin
      k <= k + 1'b1;
      if (n_idx == N_LAST) begin
        n_idx  <= '0;
        ch_idx <= ch_idx + 1'b1;
      end else begin
        n_idx <= n_idx + 1'b1;
      end
    end
  end

  // Sticky handshake error: cleared by a new job, set when the PE has no result at capture.
  always_ff @(posedge clk) begin
    if (rst)                                 err <= 1'b0;
    else if (state == S_IDLE && start_i)     err <= 1'b0;
    else if (state == S_CAPT && !pe_done)    err <= 1'b1;
  end

  // Next state and per-state strobes; everything idles at zero.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    in_rd     = 1'b0;
    in_addr   = '0;
    pe_clr    = 1'b0;
    pe_start  = 1'b0;
    pe_x      = '0;
    pe_p      = '0;
    pe_q      = '0;
    out_we    = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_CLR;
      S_CLR: begin
        pe_clr    = 1'b1;
        state_nxt = S_RD;
      end
      S_RD: begin
        in_rd     = 1'b1;
        in_addr   = k;
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        pe_start  = 1'b1;
        pe_x      = in_data;
        pe_p      = tbl_p;
        pe_q      = tbl_q;
        state_nxt = S_CAPT;
      end
      S_CAPT: begin
        out_we    = 1'b1;
        out_addr  = k;
        out_data  = pe_odata;
        state_nxt = k_last ? S_FIN : S_RD;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bn_sequencer.sv
// tb/tb_bn_sequencer.sv - directed bench for bn_sequencer with a behavioural PE and buffers
module tb_bn_sequencer;
  import bn_pkg::*;

  logic               clk, rst, start_i;
  logic               busy, done, err;
  logic               prm_we;
  logic [0:0]         prm_ch;
  logic signed [15:0] prm_p;
  logic signed [31:0] prm_q;
  logic               in_rd;
  logic [2:0]         in_addr;
  logic signed [15:0] in_data;
  logic               pe_clr, pe_start;
  logic signed [15:0] pe_x, pe_p;
  logic signed [31:0] pe_q;
  logic signed [15:0] pe_odata;
  logic               pe_done;
  logic               out_we;
  logic [2:0]         out_addr;
  logic signed [15:0] out_data;

  int total, bad;

  logic signed [15:0] in_mem [0:5] = '{16'sd100, -16'sd100, 16'sd0, -16'sd7, 16'sd7, 16'sd1000};
  logic signed [15:0] exp_dp [0:5] = '{16'sd205, -16'sd195, 16'sd5, -16'sd7, 16'sd6, 16'sd999};

  logic               hold_low;
  logic               pe_done_r;

  logic               busy_log [0:31];
  logic               done_log [0:31];
  logic               we_log   [0:31];
  logic               err_log  [0:31];
  logic [2:0]         addr_log [0:31];
  logic signed [15:0] obs      [0:5];
  logic [92:0]        rst_snap;
  int                 nwr, done_cyc;

  bn_sequencer #(.CH(2), .LEN(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .prm_we   (prm_we),
    .prm_ch   (prm_ch),
    .prm_p    (prm_p),
    .prm_q    (prm_q),
    .in_rd    (in_rd),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .pe_clr   (pe_clr),
    .pe_start (pe_start),
    .pe_x     (pe_x),
    .pe_p     (pe_p),
    .pe_q     (pe_q),
    .pe_odata (pe_odata),
    .pe_done  (pe_done),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint pe_calc(input logic signed [15:0] x, input logic signed [15:0] p,
                                     input logic signed [31:0] q);
    return (longint'(p) * longint'(x) + longint'(q)) / BN_SCALE;
  endfunction

  // Behavioural PE: registered result, sticky done, cleared by pe_clr.
  always @(posedge clk) begin
    if (rst || pe_clr) begin
      pe_odata  <= '0;
      pe_done_r <= 1'b0;
    end else if (pe_start) begin
      pe_odata  <= 16'(pe_calc(pe_x, pe_p, pe_q));
      pe_done_r <= 1'b1;
    end
  end
  assign pe_done = pe_done_r & ~hold_low;

  // Input buffer: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    if (in_rd) in_data <= in_mem[in_addr];
  end

  task automatic write_prm(input logic [0:0] ch, input logic signed [15:0] p, input logic signed [31:0] q);
    prm_we = 1'b1; prm_ch = ch; prm_p = p; prm_q = q;
    @(posedge clk); #1;
    prm_we = 1'b0;
  endtask

  task automatic do_job(input int lock_cyc, input int rst_cyc);
    for (int i = 0; i < 6; i++) obs[i] = 16'sh5555;
    nwr = 0; done_cyc = -1; rst_snap = '1;
    start_i = 1'b1;
    for (int c = 1; c < 32; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0; prm_we = 1'b0; rst = 1'b0;
      busy_log[c] = busy; done_log[c] = done; we_log[c] = out_we;
      err_log[c] = err; addr_log[c] = out_addr;
      if (out_we) begin
        nwr++;
        if (out_addr < 6) obs[out_addr] = out_data;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (c == rst_cyc + 1)
        rst_snap = {busy, done, err, in_rd, in_addr, pe_clr, pe_start, pe_x, pe_p, pe_q,
                    out_we, out_addr, out_data};
      if (c == lock_cyc) begin
        start_i = 1'b1; prm_we = 1'b1; prm_ch = 1'b0; prm_p = 16'sd1; prm_q = 32'sd0;
      end
      if (c == rst_cyc) rst = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, err, in_rd, in_addr, pe_clr, pe_start, pe_x, pe_p, pe_q, out_we, out_addr, out_data} !== 93'd0) begin
      bad++; $display("FAIL reset_outputs busy=%b done=%b err=%b in_rd=%b out_we=%b required all 0", busy, done, err, in_rd, out_we);
    end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b required 0", busy); end
  endtask

  task automatic test_latency;
    write_prm(1'b0, 16'sd2000, 32'sd5000);
    write_prm(1'b1, 16'sd1000, -32'sd500);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL latency_pre_busy got=%b required 0", busy); end
    do_job(-1, -1);
    total++;
    if (done_cyc != 20) begin bad++; $display("FAIL latency_done got=%0d required 20", done_cyc); end
    total++;
    if (nwr != 6) begin bad++; $display("FAIL latency_nwr got=%0d required 6", nwr); end
    for (int c = 1; c < 32; c++) begin
      total++;
      if (busy_log[c] !== (c <= 20)) begin bad++; $display("FAIL latency_busy c=%0d got=%b required %b", c, busy_log[c], (c <= 20)); end
      total++;
      if (done_log[c] !== (c == 20)) begin bad++; $display("FAIL latency_done_pulse c=%0d got=%b required %b", c, done_log[c], (c == 20)); end
      total++;
      if (we_log[c] !== (c >= 4 && c <= 19 && (c - 4) % 3 == 0)) begin
        bad++; $display("FAIL latency_out_we c=%0d got=%b", c, we_log[c]);
      end else if (we_log[c] === 1'b1) begin
        total++;
        if (addr_log[c] !== 3'((c - 4) / 3)) begin
          bad++; $display("FAIL latency_out_addr c=%0d got=%0d required %0d", c, addr_log[c], (c - 4) / 3);
        end
      end
    end
  endtask

  task automatic test_data_path;
    do_job(-1, -1);
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs[i] !== exp_dp[i]) begin bad++; $display("FAIL data_path k=%0d got=%0d required %0d", i, obs[i], exp_dp[i]); end
    end
  endtask

  task automatic test_busy_lockout;
    do_job(5, -1);
    total++;
    if (done_cyc != 20) begin bad++; $display("FAIL lockout_done got=%0d required 20", done_cyc); end
    total++;
    if (nwr != 6) begin bad++; $display("FAIL lockout_nwr got=%0d required 6", nwr); end
    total++;
    if (busy_log[25] !== 1'b0) begin bad++; $display("FAIL lockout_restart busy=%b required 0", busy_log[25]); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs[i] !== exp_dp[i]) begin bad++; $display("FAIL lockout_data k=%0d got=%0d required %0d", i, obs[i], exp_dp[i]); end
    end
  endtask

  task automatic test_same_cycle;
    prm_we = 1'b1; prm_ch = 1'b0; prm_p = 16'sd3000; prm_q = 32'sd0;
    do_job(-1, -1);
    total++;
    if (obs[0] !== 16'sd300) begin bad++; $display("FAIL same_cycle_k0 got=%0d required 300", obs[0]); end
    total++;
    if (obs[1] !== -16'sd300) begin bad++; $display("FAIL same_cycle_k1 got=%0d required -300", obs[1]); end
    total++;
    if (obs[3] !== -16'sd7) begin bad++; $display("FAIL same_cycle_k3 got=%0d required -7", obs[3]); end
  endtask

  task automatic test_handshake_err;
    hold_low = 1'b1;
    do_job(-1, -1);
    total++;
    if (err_log[4] !== 1'b0) begin bad++; $display("FAIL err_before_capt got=%b required 0", err_log[4]); end
    total++;
    if (err_log[5] !== 1'b1) begin bad++; $display("FAIL err_after_capt got=%b required 1", err_log[5]); end
    total++;
    if (err_log[20] !== 1'b1 || done_cyc != 20) begin
      bad++; $display("FAIL err_at_done err=%b done_cyc=%0d required 1/20", err_log[20], done_cyc);
    end
    total++;
    if (err_log[22] !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b required 1", err_log[22]); end
    hold_low = 1'b0;
    do_job(-1, -1);
    total++;
    if (err_log[1] !== 1'b0) begin bad++; $display("FAIL err_clear_on_start got=%b required 0", err_log[1]); end
    total++;
    if (err_log[22] !== 1'b0) begin bad++; $display("FAIL err_clean_job got=%b required 0", err_log[22]); end
  endtask

  task automatic test_reset_mid_job;
    do_job(-1, 8);
    total++;
    if (rst_snap !== 93'd0) begin bad++; $display("FAIL midrst_outputs got=%h required 0", rst_snap); end
    total++;
    if (done_cyc != -1) begin bad++; $display("FAIL midrst_no_done got=%0d required -1", done_cyc); end
    total++;
    if (busy_log[15] !== 1'b0 || busy_log[30] !== 1'b0) begin
      bad++; $display("FAIL midrst_no_resume busy15=%b busy30=%b required 0", busy_log[15], busy_log[30]);
    end
    do_job(-1, -1);
    total++;
    if (done_cyc != 20 || nwr != 6) begin
      bad++; $display("FAIL midrst_rerun done_cyc=%0d nwr=%0d required 20/6", done_cyc, nwr);
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (obs[i] !== 16'sd0) begin bad++; $display("FAIL midrst_zero_table k=%0d got=%0d required 0", i, obs[i]); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start_i = 1'b0; prm_we = 1'b0; prm_ch = 1'b0; prm_p = '0; prm_q = '0;
    hold_low = 1'b0;
    #1;
    test_reset;
    test_latency;
    test_data_path;
    test_busy_lockout;
    test_same_cycle;
    test_handshake_err;
    test_reset_mid_job;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bn_sequencer.md
BN_SEQUENCER -- requirements
Module: bn_sequencer

Interface
REQ-001 Parameters: CH, default 8, channel count; LEN, default 16, samples per channel; CW = clog2(CH), AW = clog2(CH*LEN), both derived.
REQ-002 Ports (clock and reset first):
- clk  in  1  clock; all logic is sequential on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  job start pulse.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse marking job completion.
- err  out  1  sticky PE-handshake error.
- prm_we  in  1  parameter write strobe.
- prm_ch  in  CW  target channel for the parameter write.
- prm_p  in  16  signed scale, r/sqrt(v+e) scaled by 1000.
- prm_q  in  32  signed offset, b - r*m/sqrt(v+e) scaled by 1000.
- in_rd  out  1  input-buffer read strobe.
- in_addr  out  AW  input-buffer address.
- in_data  in  16  signed read data, valid 1 cycle after in_rd.
- pe_clr  out  1  drives the PE rst.
- pe_start  out  1  drives the PE start.
- pe_x  out  16  signed PE x operand.
- pe_p  out  16  signed PE p operand.
- pe_q  out  32  signed PE q operand.
- pe_odata  in  16  signed PE result.
- pe_done  in  1  PE done flag (sticky in the PE).
- out_we  out  1  output-buffer write strobe.
- out_addr  out  AW  output-buffer address.
- out_data  out  16  signed output-buffer write data.

Function
REQ-003 The block SHALL hold a CH-entry parameter table of {p[15:0], q[31:0]}, written on prm_we=1 at prm_ch only while busy=0; writes while busy=1 are ignored.
REQ-004 FSM states: IDLE, CLR, RD, ISSUE, CAPT, FIN.
REQ-005 In IDLE, start_i=1 SHALL move the FSM to CLR and clear err; start_i while busy=1 is ignored.
REQ-006 CLR (1 cycle): pe_clr=1; then go to RD with element index k=0.
REQ-007 RD (1 cycle): in_rd=1 and in_addr=k; then go to ISSUE.
REQ-008 ISSUE (1 cycle): pe_start=1, pe_x=in_data, and {pe_p, pe_q}=table[k/LEN]; ordering is channel-major, k = ch*LEN + n; then go to CAPT.
REQ-009 CAPT (1 cycle): out_we=1, out_addr=k, out_data=pe_odata.
REQ-010 In CAPT, if pe_done=0 then err SHALL be set to 1.
REQ-011 From CAPT: if k = CH*LEN-1, go to FIN; else increment k and go to RD.
REQ-012 FIN (1 cycle): done=1; then go to IDLE.
REQ-013 busy=1 in every state except IDLE.
REQ-014 Latency: accepting start_i at edge 0 gives done=1 in cycle 2+3*CH*LEN, and busy=0 from the following cycle.
REQ-015 pe_start, pe_clr, in_rd, out_we and done SHALL each be 0 outside their listed state; pe_x/pe_p/pe_q are don't-care outside ISSUE and are driven 0.
REQ-016 Data SHALL pass through unmodified; the sequencer performs no arithmetic on the data path.
REQ-017 k wraps only through FIN; no out-of-range address is ever issued.
REQ-018 prm_we and start_i accepted in the same IDLE cycle: the write SHALL take effect and be used by the started job.

Reset
REQ-019 rst=1 at any cycle, including mid-job, SHALL force state IDLE and k=0.
REQ-020 On that reset every output SHALL be 0: busy, done, err, in_rd, in_addr, pe_clr, pe_start, pe_x, pe_p, pe_q, out_we, out_addr, out_data.
REQ-021 On that reset every parameter-table entry SHALL be cleared to p=0, q=0.
REQ-022 A job interrupted by reset SHALL NOT resume.

Structure
REQ-023 The FSM state encoding and the scale constant 1000 SHALL live in a shared package bn_pkg.
REQ-024 The parameter table SHALL be a single sub-module bn_param_table, with synchronous write and combinational read.
REQ-025 bn_processing_element stays external and is connected to pe_* in the parent.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Latency: CH=2, LEN=3, start_i pulse at cycle 0 -> done=1 exactly in cycle 20; busy=1 in cycles 1..20; six out_we pulses at out_addr 0..5.
- Data path: ch0 p=2000, q=5000, in_data=100 -> out_data=205.
- Negative values: ch1 p=1000, q=-500, in_data=-7 -> out_data=-7 (truncation toward zero).
- Busy lockout: start_i and prm_we during busy -> ignored; table contents and job length unchanged.
- Reset mid-job: rst=1 at cycle 8 -> all outputs 0, table zeroed; a new start then gives p=0, q=0 and out_data=0 for every element.
- Handshake error: PE model holds pe_done=0 -> err=1 after the first CAPT, err stays 1 through done, and err clears on the next start_i.
